// File: rtl/hdr_exit_detector.sv
// rtl/hdr_exit_detector.sv - I3C HDR Exit Pattern detector (4 SDA falls while SCL low).
// Optional EXIT_SYNC_EN: 2-flop synchronizers on i_scl/i_sda ahead of detection.
module hdr_exit_detector (
  input  logic i_sys_clk,
  input  logic i_sys_rst,
  input  logic i_cccnt_enable,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_cccnt_done
);

  logic scl;
  logic sda;

`ifdef EXIT_SYNC_EN
  logic [1:0] scl_sync;
  logic [1:0] sda_sync;

  // Flops reset to the bus-idle level so release never looks like an edge.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
    end else begin
      scl_sync <= {scl_sync[0], i_scl};
      sda_sync <= {sda_sync[0], i_sda};
    end
  end

  assign scl = scl_sync[1];
  assign sda = sda_sync[1];
`else
  assign scl = i_scl;
  assign sda = i_sda;
`endif

  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

  state_t     state;
  logic       sda_q;
  logic [2:0] cnt;
  logic       done_q;
  logic       fe;

  assign fe = sda_q & ~sda;

  always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) begin
      state  <= IDLE;
      sda_q  <= 1'b1;
      cnt    <= 3'd0;
      done_q <= 1'b0;
    end else begin
      // sda_q tracks SDA in every state, so enabling never sees a stale edge.
      sda_q <= sda;
      if (!i_cccnt_enable) begin
        state  <= IDLE;
        cnt    <= 3'd0;
        done_q <= 1'b0;
      end else begin
        case (state)
          IDLE, COUNT: begin
            state <= COUNT;
            if (scl) begin
              cnt <= 3'd0;
            end else if (fe && cnt == 3'd3) begin
              cnt    <= 3'd4;
              done_q <= 1'b1;
              state  <= DONE;
            end else if (fe) begin
              cnt <= cnt + 3'd1;
            end
          end
          DONE: begin
            done_q <= 1'b1;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  assign o_cccnt_done = done_q;

endmodule

// File: tb/tb_hdr_exit_detector.sv
// tb/tb_hdr_exit_detector.sv - table-driven self-checking bench for hdr_exit_detector.
module tb_hdr_exit_detector;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic scl = 1'b1;
  logic sda = 1'b1;
  logic done;

`ifdef EXIT_SYNC_EN
  localparam int HOLD = 3;
`else
  localparam int HOLD = 1;
`endif

  typedef struct packed {
    logic en;
    logic scl;
    logic sda;
    logic exp_done;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  hdr_exit_detector dut (
    .i_sys_clk     (clk),
    .i_sys_rst     (rst_n),
    .i_cccnt_enable(en),
    .i_scl         (scl),
    .i_sda         (sda),
    .o_cccnt_done  (done)
  );

  task automatic add(input logic e, input logic c, input logic d, input logic x);
    vec_t v;
    v.en       = e;
    v.scl      = c;
    v.sda      = d;
    v.exp_done = x;
    vecs.push_back(v);
  endtask

  task automatic apply(input logic e, input logic c, input logic d);
    en  = e;
    scl = c;
    sda = d;
    repeat (HOLD) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic expv);
    n_cmp++;
    if (done !== expv) begin
      n_bad++;
      $display("FAIL %s: done=%b expected %b", name, done, expv);
    end
  endtask

  initial begin
    // Full exit pattern, extra activity in DONE, then disable.
    add(1,0,1,0); add(1,0,0,0); add(1,0,1,0); add(1,0,0,0);
    add(1,0,1,0); add(1,0,0,0); add(1,0,1,0); add(1,0,0,1);
    add(1,1,0,1); add(1,1,1,1); add(1,0,0,1); add(0,1,1,0);
    // Only three falling edges.
    add(1,0,1,0); add(1,0,0,0); add(1,0,1,0); add(1,0,0,0);
    add(1,0,1,0); add(1,0,0,0); add(1,0,1,0);
    // SCL high clears the count between pairs of edges.
    add(1,1,1,0); add(1,0,0,0); add(1,0,1,0); add(1,0,0,0);
    add(1,0,1,0); add(1,1,1,0); add(1,0,0,0); add(1,0,1,0);
    add(1,0,0,0); add(1,0,1,0); add(1,0,0,0); add(1,0,1,0);
    // SCL rises on the same edge as the 4th fall.
    add(1,1,0,0); add(1,0,1,0);
    // Burst with enable low.
    for (int i = 0; i < 8; i++) add(0, 0, (i % 2 == 1), 0);
    // Enable drops on the 4th fall.
    add(1,0,1,0); add(1,0,0,0); add(1,0,1,0); add(1,0,0,0);
    add(1,0,1,0); add(1,0,0,0); add(1,0,1,0); add(0,0,0,0);
    // Re-enable with SDA low, four fresh edges.
    add(1,0,0,0); add(1,0,1,0); add(1,0,0,0); add(1,0,1,0);
    add(1,0,0,0); add(1,0,1,0); add(1,0,0,0); add(1,0,1,0);
    add(1,0,0,1);
    // One-cycle disable after done, then re-enable starting low.
    add(0,0,0,0); add(1,0,0,0); add(1,0,1,0); add(1,0,0,0);
    add(1,0,1,0); add(1,0,0,0); add(1,0,1,0); add(1,0,0,0);
    add(1,0,1,0); add(1,0,0,1);

    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("after_release", 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].en, vecs[i].scl, vecs[i].sda);
      check($sformatf("vec%0d", i), vecs[i].exp_done);
    end

    // Asynchronous reset while done is high: clears without a clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", 1'b0);
    #2;
    rst_n = 1'b1;

    // Reset mid-burst: two edges, reset, then count must restart from zero.
    apply(1, 0, 1);
    apply(1, 0, 0);
    apply(1, 0, 1);
    apply(1, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_burst_reset", 1'b0);
    rst_n = 1'b1;
    apply(1, 0, 1);
    apply(1, 0, 0);
    apply(1, 0, 1);
    apply(1, 0, 0);
    apply(1, 0, 1);
    apply(1, 0, 0);
    check("restart_three_edges", 1'b0);
    apply(1, 0, 1);
    apply(1, 0, 0);
    check("restart_fourth_edge", 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
